// File: rtl/mem_bus_master_if.sv
// Signal bundle between the execute stage, mem_bus_master and the memory-bus responder.
// The master modport is the initiator's view; the slave modport is the pipeline/responder side.
interface mem_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [21:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [3:0]  bus_wmask;
    logic        bus_wlo;
    logic        bus_olo;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               bus_addr, bus_wdata, bus_wmask, bus_wlo, bus_olo
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               bus_addr, bus_wdata, bus_wmask, bus_wlo, bus_olo
    );
endinterface

// File: rtl/mem_bus_master.sv
// Two-phase (address, then data) memory-bus initiator with lane steering and load extension.
// Optional MEM_BUS_MASTER_MISALIGN_EN: report misaligned half/word accesses instead of aligning them.
module mem_bus_master (
    input logic              clock,
    input logic              resetlo,
    mem_bus_master_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RDATA, S_WDATA} state_t;

    state_t      r_state, w_state_nxt;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;

    logic [21:0] r_bus_addr,  w_bus_addr;
    logic [31:0] r_bus_wdata, w_bus_wdata;
    logic [3:0]  r_bus_wmask, w_bus_wmask;
    logic        r_bus_wlo,   w_bus_wlo;
    logic        r_bus_olo,   w_bus_olo;
    logic        r_rsp_valid, w_rsp_valid;
    logic [31:0] r_rsp_rdata, w_rsp_rdata;

    logic        w_accept;
    logic        w_start;
    logic [23:0] w_addr_al;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_data;
    logic [31:0] w_store_data;
    logic [3:0]  w_store_mask;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

`ifdef MEM_BUS_MASTER_MISALIGN_EN
    logic w_misalign;
    logic r_err_pend;
    logic r_rsp_err;

    assign w_misalign = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                        (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    assign w_addr_al  = bus.req_addr;
    // A misaligned request is consumed here but never reaches the bus.
    assign w_start    = w_accept && !w_misalign;
    assign bus.rsp_err = r_rsp_err;
`else
    always_comb begin
        w_addr_al = bus.req_addr;
        if (bus.req_size == 2'd1)
            w_addr_al[0] = 1'b0;
        else if (bus.req_size[1])
            w_addr_al[1:0] = 2'b00;
    end
    assign w_start     = w_accept;
    assign bus.rsp_err = 1'b0;
`endif

    assign w_lane_byte = bus.bus_rdata[{r_lane, 3'b000} +: 8];
    assign w_lane_half = r_lane[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

    always_comb begin
        case (r_size)
            2'd0:    w_load_data = {{24{r_signed & w_lane_byte[7]}}, w_lane_byte};
            2'd1:    w_load_data = {{16{r_signed & w_lane_half[15]}}, w_lane_half};
            default: w_load_data = bus.bus_rdata;
        endcase
    end

    always_comb begin
        case (r_size)
            2'd0: begin
                w_store_data = {4{r_wdata[7:0]}};
                w_store_mask = ~(4'b0001 << r_lane);
            end
            2'd1: begin
                w_store_data = {2{r_wdata[15:0]}};
                w_store_mask = r_lane[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                w_store_data = r_wdata;
                w_store_mask = 4'b0000;
            end
        endcase
    end

    // NOTE: every output gets its default before the case, so no branch can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_bus_addr  = r_bus_addr;
        w_bus_wdata = r_bus_wdata;
        w_bus_wmask = 4'hF;
        w_bus_wlo   = 1'b1;
        w_bus_olo   = 1'b1;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = r_rsp_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_ADDR;
                    w_bus_addr  = w_addr_al[23:2];
                    w_bus_wlo   = !bus.req_write;
                end
            end
            S_ADDR: begin
                if (r_write) begin
                    w_state_nxt = S_WDATA;
                    w_bus_wdata = w_store_data;
                    w_bus_wmask = w_store_mask;
                end else begin
                    w_state_nxt = S_RDATA;
                    w_bus_olo   = 1'b0;
                end
            end
            S_RDATA: begin
                w_state_nxt = S_IDLE;
                w_rsp_valid = 1'b1;
                w_rsp_rdata = w_load_data;
            end
            S_WDATA: begin
                w_state_nxt = S_IDLE;
                w_rsp_valid = 1'b1;
                w_rsp_rdata = 32'h0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef MEM_BUS_MASTER_MISALIGN_EN
        if (r_err_pend) begin
            w_rsp_valid = 1'b1;
            w_rsp_rdata = 32'h0;
        end
`endif
    end

    // NOTE: all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetlo) begin
        if (!resetlo) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_size      <= 2'd0;
            r_signed    <= 1'b0;
            r_lane      <= 2'd0;
            r_wdata     <= 32'h0;
            r_bus_addr  <= 22'h0;
            r_bus_wdata <= 32'h0;
            r_bus_wmask <= 4'hF;
            r_bus_wlo   <= 1'b1;
            r_bus_olo   <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_addr  <= w_bus_addr;
            r_bus_wdata <= w_bus_wdata;
            r_bus_wmask <= w_bus_wmask;
            r_bus_wlo   <= w_bus_wlo;
            r_bus_olo   <= w_bus_olo;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            if (w_start) begin
                r_write  <= bus.req_write;
                r_size   <= bus.req_size;
                r_signed <= bus.req_signed;
                r_lane   <= w_addr_al[1:0];
                r_wdata  <= bus.req_wdata;
            end
        end
    end

`ifdef MEM_BUS_MASTER_MISALIGN_EN
    always_ff @(posedge clock or negedge resetlo) begin
        if (!resetlo) begin
            r_err_pend <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_err_pend <= w_accept && w_misalign;
            if (r_err_pend)
                r_rsp_err <= 1'b1;
            else if (w_rsp_valid)
                r_rsp_err <= 1'b0;
        end
    end
`endif

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;
    assign bus.bus_wmask = r_bus_wmask;
    assign bus.bus_wlo   = r_bus_wlo;
    assign bus.bus_olo   = r_bus_olo;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: directed vector table, reset/misalign sequences, and random traffic
// checked against a byte-addressed memory model. Honours MEM_BUS_MASTER_MISALIGN_EN like the RTL.
module tb_mem_bus_master;

    logic clock = 1'b0;
    logic resetlo;
    always #5 clock = ~clock;

    mem_bus_master_if u_if ();
    mem_bus_master dut (.clock(clock), .resetlo(resetlo), .bus(u_if));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- responder: word memory with active-low byte mask ----------------
    logic [31:0] resp_mem [logic [21:0]];
    logic        wr_pend = 1'b0;
    logic [21:0] wr_addr = 22'h0;
    int          cnt_wlo = 0;
    int          cnt_olo = 0;

    function automatic logic [31:0] init_word(input logic [21:0] wa);
        return {wa[9:0], 2'b01, wa[9:0], 10'h2A5} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] resp_rd(input logic [21:0] wa);
        if (resp_mem.exists(wa)) return resp_mem[wa];
        return init_word(wa);
    endfunction

    function automatic void resp_commit(input logic [21:0] wa, input logic [31:0] wd,
                                        input logic [3:0] wm);
        logic [31:0] w;
        w = resp_rd(wa);
        for (int i = 0; i < 4; i++)
            if (!wm[i]) w[8*i +: 8] = wd[8*i +: 8];
        resp_mem[wa] = w;
    endfunction

    // Responder samples mid-cycle: address phase on one negedge, data phase on the next.
    always @(negedge clock) begin
        if (!u_if.bus_olo) u_if.bus_rdata = resp_rd(u_if.bus_addr);
        else               u_if.bus_rdata = $urandom;
        if (wr_pend) resp_commit(wr_addr, u_if.bus_wdata, u_if.bus_wmask);
        wr_pend = !u_if.bus_wlo;
        if (!u_if.bus_wlo) begin
            wr_addr = u_if.bus_addr;
            cnt_wlo++;
        end
        if (!u_if.bus_olo) cnt_olo++;
    end

    // ---------------- reference model: flat byte memory ----------------
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] ref_byte(input int a);
        logic [31:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = init_word(22'(a >> 2));
        return w[8*(a % 4) +: 8];
    endfunction

    task automatic ref_access(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [23:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err);
        int n, a, base;
        logic [31:0] v;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a    = int'(addr);
        rd   = 32'h0;
        err  = 1'b0;
`ifdef MEM_BUS_MASTER_MISALIGN_EN
        if (a % n != 0) begin
            err = 1'b1;
            return;
        end
`endif
        base = a - (a % n);
        if (wr) begin
            for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(base + i);
            if (sg && n < 4 && v[8*n - 1])
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rd = v;
        end
    endtask

    task automatic preload(input logic [21:0] wa, input logic [31:0] d);
        resp_mem[wa] = d;
        for (int i = 0; i < 4; i++) ref_mem[int'(wa) * 4 + i] = d[8*i +: 8];
    endtask

    // ---------------- request driver ----------------
    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [23:0] addr, input logic [31:0] wd);
        logic rdy;
        logic ok;
        ok = 1'b0;
        u_if.req_write  = wr;
        u_if.req_size   = sz;
        u_if.req_signed = sg;
        u_if.req_addr   = addr;
        u_if.req_wdata  = wd;
        u_if.req_valid  = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            rdy = u_if.req_ready;
            @(posedge clock);
            ok = rdy;
        end
        #1;
        u_if.req_valid = 1'b0;
        u_if.req_addr  = $urandom;
        u_if.req_wdata = $urandom;
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    endtask

    // Edges from accept until rsp_valid is seen; bounded.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!u_if.rsp_valid && lat < 8) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [23:0] addr;
        logic [31:0] wd;
        logic [21:0] e_baddr;
        logic [31:0] e_wdata;
        logic [3:0]  e_mask;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [13];
    int   n_vec;

    initial begin
        logic [31:0] m_rd;
        logic        m_err;
        int          lat;
        int          c_wlo, c_olo;
        logic        seen;

        u_if.req_valid  = 1'b0;
        u_if.req_write  = 1'b0;
        u_if.req_size   = 2'd0;
        u_if.req_signed = 1'b0;
        u_if.req_addr   = 24'h0;
        u_if.req_wdata  = 32'h0;
        u_if.bus_rdata  = 32'h0;
        resetlo = 1'b0;

        // ---- reset ----
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetlo = 1'b1;
        @(posedge clock);
        #1;
        check("rst_wlo",    32'(u_if.bus_wlo),   32'd1);
        check("rst_olo",    32'(u_if.bus_olo),   32'd1);
        check("rst_wmask",  32'(u_if.bus_wmask), 32'hF);
        check("rst_ready",  32'(u_if.req_ready), 32'd1);
        check("rst_rvalid", 32'(u_if.rsp_valid), 32'd0);
        check("rst_addr",   32'(u_if.bus_addr),  32'd0);
        check("rst_wdata",  u_if.bus_wdata,      32'd0);
        check("rst_rdata",  u_if.rsp_rdata,      32'd0);
        check("rst_err",    32'(u_if.rsp_err),   32'd0);

        // ---- directed table ----
        preload(22'h80,     32'h80FF_1234);
        preload(22'h4,      32'h1234_ABCD);
        preload(22'h3FFFFC, 32'h0000_0000);
        //             wr  sz    sg    addr          wd             baddr      wdata          mask     rdata
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 24'h000104, 32'hDEADBEEF, 22'h41,     32'hDEADBEEF, 4'b0000, 32'h0};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 24'h000203, 32'h0,        22'h80,     32'h0,        4'hF,    32'hFFFFFF80};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 24'h000203, 32'h0,        22'h80,     32'h0,        4'hF,    32'h00000080};
        vecs[3]  = '{1'b0, 2'd1, 1'b1, 24'h000202, 32'h0,        22'h80,     32'h0,        4'hF,    32'hFFFF80FF};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 24'h000201, 32'h0,        22'h80,     32'h0,        4'hF,    32'h00000012};
        vecs[5]  = '{1'b1, 2'd0, 1'b0, 24'hFFFFF0, 32'h00000041, 22'h3FFFFC, 32'h41414141, 4'b1110, 32'h0};
        vecs[6]  = '{1'b1, 2'd1, 1'b0, 24'hFFFFF2, 32'h00000001, 22'h3FFFFC, 32'h00010001, 4'b0011, 32'h0};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 24'h000106, 32'h0000AB7E, 22'h41,     32'h7E7E7E7E, 4'b1011, 32'h0};
        vecs[8]  = '{1'b0, 2'd3, 1'b0, 24'h000104, 32'h0,        22'h41,     32'h0,        4'hF,    32'hDE7EBEEF};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 24'h000100, 32'h1234CAFE, 22'h40,     32'hCAFECAFE, 4'b1100, 32'h0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 24'h000100, 32'h0,        22'h40,     32'h0,        4'hF,    32'h0000CAFE};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 24'hFFFFF0, 32'h0,        22'h3FFFFC, 32'h0,        4'hF,    32'h00010041};
        vecs[12] = '{1'b0, 2'd1, 1'b1, 24'h000011, 32'h0,        22'h4,      32'h0,        4'hF,    32'hFFFFABCD};
`ifdef MEM_BUS_MASTER_MISALIGN_EN
        n_vec = 12;
`else
        n_vec = 13;
`endif

        for (int v = 0; v < n_vec; v++) begin
            c_wlo = cnt_wlo;
            c_olo = cnt_olo;
            issue(vecs[v].wr, vecs[v].sz, vecs[v].sg, vecs[v].addr, vecs[v].wd);
            ref_access(vecs[v].wr, vecs[v].sz, vecs[v].sg, vecs[v].addr, vecs[v].wd, m_rd, m_err);
            check($sformatf("v%0d_a_addr", v),   32'(u_if.bus_addr),  32'(vecs[v].e_baddr));
            check($sformatf("v%0d_a_wlo", v),    32'(u_if.bus_wlo),   32'(!vecs[v].wr));
            check($sformatf("v%0d_a_olo", v),    32'(u_if.bus_olo),   32'd1);
            check($sformatf("v%0d_a_wmask", v),  32'(u_if.bus_wmask), 32'hF);
            check($sformatf("v%0d_a_ready", v),  32'(u_if.req_ready), 32'd0);
            check($sformatf("v%0d_a_rvalid", v), 32'(u_if.rsp_valid), 32'd0);
            @(posedge clock);
            #1;
            if (vecs[v].wr) begin
                check($sformatf("v%0d_d_wdata", v), u_if.bus_wdata, vecs[v].e_wdata);
                check($sformatf("v%0d_d_wmask", v), 32'(u_if.bus_wmask), 32'(vecs[v].e_mask));
                check($sformatf("v%0d_d_wlo", v),   32'(u_if.bus_wlo),   32'd1);
            end else begin
                check($sformatf("v%0d_d_olo", v),   32'(u_if.bus_olo),   32'd0);
                check($sformatf("v%0d_d_wmask", v), 32'(u_if.bus_wmask), 32'hF);
            end
            check($sformatf("v%0d_d_addr", v), 32'(u_if.bus_addr), 32'(vecs[v].e_baddr));
            @(posedge clock);
            #1;
            check($sformatf("v%0d_r_valid", v), 32'(u_if.rsp_valid), 32'd1);
            check($sformatf("v%0d_r_rdata", v), u_if.rsp_rdata,      vecs[v].e_rdata);
            check($sformatf("v%0d_r_err", v),   32'(u_if.rsp_err),   32'd0);
            check($sformatf("v%0d_r_ready", v), 32'(u_if.req_ready), 32'd1);
            check($sformatf("v%0d_r_wmask", v), 32'(u_if.bus_wmask), 32'hF);
            check($sformatf("v%0d_r_olo", v),   32'(u_if.bus_olo),   32'd1);
            check($sformatf("v%0d_wlo_cycles", v), 32'(cnt_wlo - c_wlo), vecs[v].wr ? 32'd1 : 32'd0);
            check($sformatf("v%0d_olo_cycles", v), 32'(cnt_olo - c_olo), vecs[v].wr ? 32'd0 : 32'd1);
        end
        @(posedge clock);
        #1;
        check("idle_rvalid", 32'(u_if.rsp_valid), 32'd0);

`ifdef MEM_BUS_MASTER_MISALIGN_EN
        // ---- misaligned half load: error response, no bus activity ----
        c_wlo = cnt_wlo;
        c_olo = cnt_olo;
        issue(1'b0, 2'd1, 1'b0, 24'h000011, 32'h0);
        check("mis_e0_rvalid", 32'(u_if.rsp_valid), 32'd0);
        check("mis_e0_ready",  32'(u_if.req_ready), 32'd1);
        @(posedge clock);
        #1;
        check("mis_rvalid", 32'(u_if.rsp_valid), 32'd1);
        check("mis_err",    32'(u_if.rsp_err),   32'd1);
        check("mis_rdata",  u_if.rsp_rdata,      32'd0);
        @(posedge clock);
        #1;
        check("mis_rvalid_off", 32'(u_if.rsp_valid), 32'd0);
        check("mis_no_wlo", 32'(cnt_wlo - c_wlo), 32'd0);
        check("mis_no_olo", 32'(cnt_olo - c_olo), 32'd0);
`endif

        // ---- reset during WDATA ----
        preload(22'h30, 32'hA1B2_C3D4);
        issue(1'b1, 2'd2, 1'b0, 24'h0000C0, 32'h1122_3344);
        @(posedge clock);
        #1;
        check("rw_wdata_mask", 32'(u_if.bus_wmask), 32'h0);
        resetlo = 1'b0;
        #1;
        check("rw_mask_f",  32'(u_if.bus_wmask), 32'hF);
        check("rw_wlo",     32'(u_if.bus_wlo),   32'd1);
        check("rw_olo",     32'(u_if.bus_olo),   32'd1);
        check("rw_ready",   32'(u_if.req_ready), 32'd1);
        check("rw_addr",    32'(u_if.bus_addr),  32'd0);
        @(negedge clock);
        #1;
        resetlo = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            if (u_if.rsp_valid) seen = 1'b1;
        end
        check("rw_no_rsp", 32'(seen), 32'd0);
        issue(1'b0, 2'd2, 1'b0, 24'h0000C0, 32'h0);
        ref_access(1'b0, 2'd2, 1'b0, 24'h0000C0, 32'h0, m_rd, m_err);
        wait_rsp(lat);
        check("rw_unwritten", u_if.rsp_rdata, m_rd);
        @(posedge clock);
        #1;
        issue(1'b1, 2'd2, 1'b0, 24'h0000C0, 32'h5566_7788);
        ref_access(1'b1, 2'd2, 1'b0, 24'h0000C0, 32'h5566_7788, m_rd, m_err);
        wait_rsp(lat);
        check("rw_after_lat", 32'(lat), 32'd2);
        issue(1'b0, 2'd2, 1'b0, 24'h0000C0, 32'h0);
        ref_access(1'b0, 2'd2, 1'b0, 24'h0000C0, 32'h0, m_rd, m_err);
        wait_rsp(lat);
        check("rw_after_data", u_if.rsp_rdata, m_rd);

        // ---- random traffic against the byte model ----
        for (int t = 0; t < 300; t++) begin
            logic        wr, sg;
            logic [1:0]  sz;
            logic [23:0] addr;
            logic [31:0] wd;
            wr   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom);
            sg   = 1'($urandom);
            addr = 24'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) addr = addr | 24'hFFFF00;
            wd   = $urandom;
            c_wlo = cnt_wlo;
            c_olo = cnt_olo;
            issue(wr, sz, sg, addr, wd);
            ref_access(wr, sz, sg, addr, wd, m_rd, m_err);
            wait_rsp(lat);
            check($sformatf("rnd%0d_lat", t),   32'(lat), m_err ? 32'd1 : 32'd2);
            check($sformatf("rnd%0d_rdata", t), u_if.rsp_rdata, m_rd);
            check($sformatf("rnd%0d_err", t),   32'(u_if.rsp_err), 32'(m_err));
            if (m_err) begin
                check($sformatf("rnd%0d_quiet", t), 32'((cnt_wlo - c_wlo) + (cnt_olo - c_olo)), 32'd0);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Initiator for the core's 24-bit, 32-bit-data memory bus: converts one load/store request from the execute stage into the bus's two-phase cycle (address phase, then data phase). Handles byte-lane steering, the active-low write mask, and sign/zero extension of loads. Sits between the CPU pipeline and `memoryspace` or any other bus responder; it is the only driver of the bus address and strobes.

## Interface
Parameters: none.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `resetlo`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `req_signed`  in  1  sign-extend a byte or half load.
- `req_addr`  in  24  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  one-cycle pulse; the transaction has completed.
- `rsp_rdata`  out  32  load result, extended; 0 for stores.
- `rsp_err`  out  1  misaligned access (see Configuration); valid with `rsp_valid`.
- `bus_addr`  out  22  word address [23:2].
- `bus_wdata`  out  32  write data, lane-steered.
- `bus_rdata`  in  32  read data from the responder.
- `bus_wmask`  out  4  active-low byte write enables, one per lane.
- `bus_wlo`  out  1  active-low write request; sampled with `bus_addr`.
- `bus_olo`  out  1  active-low responder output enable.

## Operation
The design is a state machine with states IDLE, ADDR, RDATA and WDATA. All outputs are registered except `req_ready`, which equals (state == IDLE).

- **IDLE:** On accept, latch the request, compute lanes and go to ADDR. Misaligned handling is described under Configuration.
- **ADDR:** `bus_addr` = latched address [23:2]; `bus_wlo` = !write; `bus_olo` = 1; `bus_wmask` = 4'hF. Next state is WDATA for a store and RDATA for a load.
- **RDATA:** `bus_olo` = 0; `bus_wlo` = 1; `bus_addr` is held. On the edge:
  - capture `bus_rdata`;
  - select lane `addr[1:0]` for a byte or `addr[1]` for a half;
  - extend: sign if `req_signed`, else zero;
  - drive `rsp_rdata`, pulse `rsp_valid`, go to IDLE.
- **WDATA:** `bus_wlo` = 1, which is required so the responder does not open a second write; `bus_olo` = 1.
  - Byte: `bus_wdata` = byte replicated four times; `bus_wmask` = ~(1<<addr[1:0]).
  - Half: `bus_wdata` = half replicated twice; `bus_wmask` = addr[1] ? 4'b0011 : 4'b1100.
  - Word: data as given; mask 4'b0000.
  - On the edge: `bus_wmask` returns to F, pulse `rsp_valid` with `rsp_rdata` = 0, go to IDLE.
- **No special-casing of the console address 0xFFFFF0:** it is an ordinary access. For example, a byte store produces mask 4'b1110.
- **Between transactions:** `bus_addr` and `bus_wdata` hold their last values; the strobes stay deasserted.

## Timing
- Accept at edge E0. Address phase in cycle E0–E1; the responder samples `bus_addr`/`bus_wlo` at E1.
- Data phase in cycle E1–E2; the responder commits the write, or the master captures `bus_rdata`, at E2.
- `rsp_valid` is high in cycle E2–E3. `req_ready` is high again from E2, so the next accept is at E3. Throughput is one access per 3 cycles.
- **Reset values:**
  - state IDLE, so `req_ready` = 1;
  - `bus_wlo` = 1, `bus_olo` = 1, `bus_wmask` = 4'hF;
  - `bus_addr` = 0, `bus_wdata` = 0;
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- **Reset mid-transaction:** asserting `resetlo` forces all outputs to their reset values immediately.
  - An abandoned WDATA reaches the responder with mask F, so no bytes are written.
  - No `rsp_valid` is produced for the abandoned request.
- `req_valid` while busy is ignored; the request must be held until accepted. Request inputs are not sampled after the accept edge.

## Configuration
Macro: `MEM_BUS_MASTER_MISALIGN_EN`.
- **Defined:**
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is accepted but starts no bus cycle.
  - On the edge after accept: `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0; state remains IDLE.
  - Aligned accesses return `rsp_err` = 0.
- **Undefined:**
  - Low address bits are forced to natural alignment: half clears bit 0, word clears bits [1:0].
  - `rsp_err` is constant 0 and no misalignment logic is generated.

## Test plan
- **Reset:** release `resetlo` → `bus_wlo`=1, `bus_olo`=1, `bus_wmask`=F, `req_ready`=1, `rsp_valid`=0.
- **Word store:** addr 0x000104, data 0xDEADBEEF → after E1 `bus_addr`=0x41, `bus_wlo`=0 for exactly one cycle; next cycle `bus_wdata`=DEADBEEF, `bus_wmask`=0000; `rsp_valid` at E2.
- **Signed byte load:** byte load, signed, addr 0x000203, responder word 0x80FF1234 → `rsp_rdata`=0xFFFFFF80. Unsigned gives 0x00000080. `bus_olo` is low only in the RDATA cycle.
- **Console byte store:** addr 0xFFFFF0, data 0x41 → `bus_wdata`=0x41414141, `bus_wmask`=1110. Half store, addr 0xFFFFF2, data 0x0001 → `bus_wmask`=0011, `bus_wdata`=0x00010001.
- **Misaligned access:** half load at 0x000011 → with the macro defined, `rsp_err`=1 one cycle after accept and no `bus_olo`/`bus_wlo` activity; without the macro, the bus reads word 0x4 and returns lanes [15:0].
- **Reset during WDATA:** for a store, assert `resetlo` in the WDATA cycle → `bus_wmask`=F immediately, no `rsp_valid`; the next request completes normally.
